stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-input, WIDTH-bit streaming multiplexer with a registered output stage and valid/ready handshakes on every port. Channel selection is either fixed (external `sel`) or round-robin across requesting inputs, chosen at run time by `mode`. It is the sequential, flow-controlled successor of the combinational 4:1 MUX and sits between multiple producer streams and a single consumer.

## Interface
- `N_IN`, default 4: number of input channels; legal range 2..16.
- `WIDTH`, default 8: data width per channel.
- `SEL_W`, default `$clog2(N_IN)`: width of `sel` and `out_chan`; derived, not overridden.
- `clk`  input  1  rising-edge clock, single clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `in_data`  input  N_IN*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  input  N_IN  per-channel valid.
- `in_ready`  output  N_IN  per-channel ready; at most one bit high per cycle.
- `mode`  input  1  0 = fixed select, 1 = round-robin.
- `sel`  input  SEL_W  channel chosen in fixed mode; values >= N_IN select nothing.
- `out_data`  output  WIDTH  registered output data.
- `out_valid`  output  1  output register holds a word.
- `out_ready`  input  1  consumer accepts the word.
- `out_chan`  output  SEL_W  source channel index of `out_data`.

## Operation
- Output stage: one-entry register. `load_en = !out_valid || out_ready`.
- Grant (combinational, evaluated every cycle):
  - mode 0: `gnt = sel` if `sel < N_IN` and `in_valid[sel]`; otherwise no grant.
  - mode 1: first channel with `in_valid` set, searching `ptr, ptr+1, …, N_IN-1, 0, …, ptr-1` (wrap modulo N_IN); no grant if no valid input.
- `in_ready[i] = load_en && grant_valid && (gnt == i)`; all other bits 0.
- Input transfer on channel i: `in_valid[i] && in_ready[i]` in the same cycle.
- On input transfer: `out_data <= in_data[gnt]`, `out_chan <= gnt`, `out_valid <= 1`.
- On output transfer without a simultaneous input transfer: `out_valid <= 0`; `out_data`/`out_chan` hold their last value.
- Simultaneous output and input transfer: register reloads in the same edge, `out_valid` stays 1 (full throughput, one word per cycle).
- Round-robin pointer `ptr` (SEL_W bits, range 0..N_IN-1):
  - updates only on an input transfer while mode = 1: `ptr <= (gnt == N_IN-1) ? 0 : gnt+1`.
  - holds in mode 0 and on cycles with no transfer.
- Backpressure: while `out_valid && !out_ready`, every `in_ready` is 0; the output register and `ptr` hold.
- `mode`/`sel` are sampled every cycle; a change affects only the next grant and never disturbs a word already in the output register.
- Inputs may drop `in_valid` without a transfer; the block keeps no per-input state.

## Timing
- Reset (`rst` high at a rising edge): `out_valid = 0`, `out_data = 0`, `out_chan = 0`, `ptr = 0`; `in_ready` = 0 on the cycle `rst` is high. Reset mid-stream drops the held word with no output transfer.
- Latency: an input word accepted at edge k appears on `out_data` with `out_valid = 1` after edge k, i.e. one cycle.
- Throughput: 1 word/cycle with `out_ready` held high.
- `in_ready` depends combinationally on `out_ready`, `out_valid`, `in_valid`, `mode`, `sel`, `ptr`; `out_*` are register outputs only.
- No combinational path from `in_data` to `out_data`.

## Test plan
- Reset: hold `rst` 2 cycles with all `in_valid` = 4'b1111 -> `out_valid` = 0, `out_data` = 0, `out_chan` = 0, `in_ready` = 0; the first grant after release goes to channel 0.
- Fixed mode sweep (N_IN=4, WIDTH=8): mode 0, `in_data` = {8'hDD,8'hCC,8'hBB,8'hAA}, all valid, `out_ready` = 1, `sel` 0,1,2,3 on successive cycles -> one cycle later `out_data` = AA,BB,CC,DD with `out_chan` 0,1,2,3.
- Round-robin fairness: mode 1, all four valid, `out_ready` = 1 for 8 cycles -> `out_chan` sequence 0,1,2,3,0,1,2,3; with only channels 1 and 3 valid -> 1,3,1,3.
- Backpressure: mode 1, `out_ready` = 0 for 3 cycles after first load -> `out_data`/`out_chan` stable, `in_ready` = 0, `ptr` unchanged; releasing `out_ready` resumes with the next channel in order and loses no word.
- Invalid and idle select: mode 0, `sel` = 2 with `in_valid[2]` = 0 -> `in_ready` = 0, `out_valid` falls after the pending word drains; N_IN=3 with `sel` = 3 -> no grant.
- Reset mid-operation and mode switch: in mode 1 at `ptr` = 2, assert `rst` for 1 cycle -> `ptr` = 0, `out_valid` = 0; then switch mode 0 -> 1 while a word is held -> held word and `out_chan` unchanged until the output transfer completes.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-input streaming multiplexer with fixed or round-robin channel selection,
// valid/ready handshakes on every port and a one-entry registered output stage.
module stream_mux_rr #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_chan
);

  localparam logic [SEL_W:0]   N_W  = (SEL_W+1)'(N_IN);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);

  logic             load_en_s;
  logic             gnt_valid_s;
  logic [SEL_W-1:0] gnt_s;
  logic [SEL_W:0]   sum_s;
  logic [SEL_W-1:0] idx_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             xfer_in_s;
  logic [SEL_W-1:0] ptr_r;

  assign load_en_s = !out_valid || out_ready;
  assign xfer_in_s = |(in_valid & in_ready);

  // Grant selection: fixed channel in mode 0, rotating priority from ptr_r in mode 1
  always_comb begin
    gnt_s       = '0;
    gnt_valid_s = 1'b0;
    sum_s       = '0;
    idx_s       = '0;
    if (mode == 1'b0) begin
      for (int i = 0; i < N_IN; i++) begin
        if ((sel == SEL_W'(i)) && in_valid[i]) begin
          gnt_s       = SEL_W'(i);
          gnt_valid_s = 1'b1;
        end else begin
          gnt_s       = gnt_s;
          gnt_valid_s = gnt_valid_s;
        end
      end
    end else begin
      // Walk from the farthest offset down so the nearest valid channel wins last.
      for (int k = N_IN - 1; k >= 0; k--) begin
        sum_s = {1'b0, ptr_r} + (SEL_W+1)'(k);
        idx_s = (sum_s >= N_W) ? SEL_W'(sum_s - N_W) : SEL_W'(sum_s);
        if (in_valid[idx_s]) begin
          gnt_s       = idx_s;
          gnt_valid_s = 1'b1;
        end else begin
          gnt_s       = gnt_s;
          gnt_valid_s = gnt_valid_s;
        end
      end
    end
  end

  // Per-channel ready and data selection for the granted channel
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_ready[i] = !rst && load_en_s && gnt_valid_s && (gnt_s == SEL_W'(i));
      sel_data_s  = (gnt_s == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : sel_data_s;
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr_r     <= '0;
    end else if (xfer_in_s) begin
      out_valid <= 1'b1;
      out_data  <= sel_data_s;
      out_chan  <= gnt_s;
      if (mode == 1'b1) begin
        ptr_r <= (gnt_s == LAST) ? '0 : gnt_s + SEL_W'(1);
      end else begin
        ptr_r <= ptr_r;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a 4-channel instance for the main
// scenarios and a 3-channel instance for the out-of-range select case.
module tb_stream_mux_rr;

  typedef struct packed {
    logic [1:0] chan;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [1:0]  out_chan;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic        out_valid3, out_ready3;
  logic [1:0]  out_chan3;

  int   checks = 0;
  int   failures = 0;
  int   mptr = 0;
  int   g;
  exp_t e;
  exp_t sbq[$];
  int   rr_seq[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};

  always #5 clk = ~clk;

  stream_mux_rr #(.N_IN(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan)
  );

  stream_mux_rr #(.N_IN(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_chan(out_chan3)
  );

  // Reference grant: -1 when nothing is granted.
  function automatic int model_gnt(input logic m, input int s, input logic [3:0] v, input int p);
    if (!m) return (s < 4 && v[s]) ? s : -1;
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] rdy_of(input int gg);
    return (gg < 0) ? 4'b0000 : 4'(1 << gg);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 4'hF; mode = 1'b1; out_ready = 1'b1; in_valid3 = 3'b111;
    repeat (2) begin
      tick;
      checks++;
      if ({out_valid, out_data, out_chan} !== 11'd0) begin
        failures++;
        $display("FAIL reset_out got v=%b d=%h c=%0d exp all zero", out_valid, out_data, out_chan);
      end
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
      end
      checks++;
      if (out_valid3 !== 1'b0) begin
        failures++;
        $display("FAIL reset_out_valid3 got=%b exp=0", out_valid3);
      end
    end
    rst = 1'b0; mptr = 0; in_valid3 = 3'b000;
    #1;
    g = model_gnt(mode, sel, in_valid, mptr);
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got=%b exp=0001", in_ready);
    end
    sbq.push_back('{chan: 2'(g), data: in_data[g*8 +: 8]});
    mptr = (g == 3) ? 0 : g + 1;
    tick;
    e = sbq.pop_front();
    checks++;
    if ({out_valid, out_chan, out_data} !== {1'b1, e.chan, e.data}) begin
      failures++;
      $display("FAIL reset_first_word got v=%b c=%0d d=%h exp v=1 c=%0d d=%h",
               out_valid, out_chan, out_data, e.chan, e.data);
    end
    in_valid = 4'h0;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_fixed_sweep;
    mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      g = model_gnt(mode, sel, in_valid, mptr);
      checks++;
      if (in_ready !== rdy_of(g)) begin
        failures++;
        $display("FAIL fixed_in_ready sel=%0d got=%b exp=%b", s, in_ready, rdy_of(g));
      end
      sbq.push_back('{chan: 2'(g), data: in_data[g*8 +: 8]});
      tick;
      e = sbq.pop_front();
      checks++;
      if ({out_valid, out_chan, out_data} !== {1'b1, e.chan, e.data}) begin
        failures++;
        $display("FAIL fixed_word sel=%0d got v=%b c=%0d d=%h exp c=%0d d=%h",
                 s, out_valid, out_chan, out_data, e.chan, e.data);
      end
    end
    in_valid = 4'h0;
    tick;
  endtask

  task automatic test_rr_fair;
    rst = 1'b1;
    tick;
    rst = 1'b0; mptr = 0; mode = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8) ? 4'hF : 4'b1010;
      in_data  = $urandom;
      #1;
      g = model_gnt(mode, sel, in_valid, mptr);
      checks++;
      if (in_ready !== rdy_of(g)) begin
        failures++;
        $display("FAIL rr_in_ready cyc=%0d got=%b exp=%b", c, in_ready, rdy_of(g));
      end
      sbq.push_back('{chan: 2'(g), data: in_data[g*8 +: 8]});
      mptr = (g == 3) ? 0 : g + 1;
      tick;
      e = sbq.pop_front();
      checks++;
      if ({out_valid, out_chan, out_data} !== {1'b1, 2'(rr_seq[c]), e.data}) begin
        failures++;
        $display("FAIL rr_word cyc=%0d got v=%b c=%0d d=%h exp c=%0d d=%h",
                 c, out_valid, out_chan, out_data, rr_seq[c], e.data);
      end
    end
    in_valid = 4'h0;
    tick;
  endtask

  task automatic test_backpressure;
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    #1;
    g = model_gnt(mode, sel, in_valid, mptr);
    checks++;
    if (in_ready !== rdy_of(g)) begin
      failures++;
      $display("FAIL bp_first_ready got=%b exp=%b", in_ready, rdy_of(g));
    end
    sbq.push_back('{chan: 2'(g), data: in_data[g*8 +: 8]});
    mptr = (g == 3) ? 0 : g + 1;
    tick;
    e = sbq.pop_front();
    repeat (3) begin
      checks++;
      if ({out_valid, out_chan, out_data, in_ready} !== {1'b1, e.chan, e.data, 4'b0000}) begin
        failures++;
        $display("FAIL bp_hold got v=%b c=%0d d=%h rdy=%b exp v=1 c=%0d d=%h rdy=0000",
                 out_valid, out_chan, out_data, in_ready, e.chan, e.data);
      end
      tick;
    end
    out_ready = 1'b1;
    #1;
    g = model_gnt(mode, sel, in_valid, mptr);
    checks++;
    if (in_ready !== rdy_of(g)) begin
      failures++;
      $display("FAIL bp_resume_ready got=%b exp=%b", in_ready, rdy_of(g));
    end
    sbq.push_back('{chan: 2'(g), data: in_data[g*8 +: 8]});
    mptr = (g == 3) ? 0 : g + 1;
    tick;
    e = sbq.pop_front();
    checks++;
    if ({out_valid, out_chan, out_data} !== {1'b1, e.chan, e.data}) begin
      failures++;
      $display("FAIL bp_resume_word got v=%b c=%0d d=%h exp c=%0d d=%h",
               out_valid, out_chan, out_data, e.chan, e.data);
    end
    in_valid = 4'h0;
    tick;
  endtask

  task automatic test_invalid_sel;
    mode = 1'b0; in_valid = 4'b1011; out_ready = 1'b1; sel = 2'd0;
    #1;
    g = model_gnt(mode, sel, in_valid, mptr);
    sbq.push_back('{chan: 2'(g), data: in_data[g*8 +: 8]});
    tick;
    e = sbq.pop_front();
    checks++;
    if ({out_valid, out_chan, out_data} !== {1'b1, e.chan, e.data}) begin
      failures++;
      $display("FAIL idle_first_word got v=%b c=%0d d=%h exp c=%0d d=%h",
               out_valid, out_chan, out_data, e.chan, e.data);
    end
    sel = 2'd2;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL idle_in_ready got=%b exp=0000", in_ready);
    end
    tick;
    checks++;
    if ({out_valid, in_ready} !== 5'b0) begin
      failures++;
      $display("FAIL idle_drain got v=%b rdy=%b exp v=0 rdy=0000", out_valid, in_ready);
    end
    in_valid = 4'h0;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    in_data3 = {8'h33, 8'h22, 8'h11};
    #1;
    checks++;
    if (in_ready3 !== 3'b000) begin
      failures++;
      $display("FAIL n3_sel3_ready got=%b exp=000", in_ready3);
    end
    tick;
    checks++;
    if (out_valid3 !== 1'b0) begin
      failures++;
      $display("FAIL n3_sel3_valid got=%b exp=0", out_valid3);
    end
    sel3 = 2'd2;
    #1;
    checks++;
    if (in_ready3 !== 3'b100) begin
      failures++;
      $display("FAIL n3_sel2_ready got=%b exp=100", in_ready3);
    end
    tick;
    checks++;
    if ({out_valid3, out_chan3, out_data3} !== {1'b1, 2'd2, 8'h33}) begin
      failures++;
      $display("FAIL n3_sel2_word got v=%b c=%0d d=%h exp v=1 c=2 d=33", out_valid3, out_chan3, out_data3);
    end
    in_valid3 = 3'b000;
  endtask

  task automatic test_reset_mode_switch;
    mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
    #1;
    g = model_gnt(mode, sel, in_valid, mptr);
    sbq.push_back('{chan: 2'(g), data: in_data[g*8 +: 8]});
    mptr = (g == 3) ? 0 : g + 1;
    tick;
    e = sbq.pop_front();
    checks++;
    if ({out_valid, out_chan, out_data} !== {1'b1, e.chan, e.data}) begin
      failures++;
      $display("FAIL ms_pre_word got v=%b c=%0d d=%h exp c=%0d d=%h",
               out_valid, out_chan, out_data, e.chan, e.data);
    end
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL ms_rst_ready got=%b exp=0000", in_ready);
    end
    tick;
    checks++;
    if ({out_valid, out_chan, out_data} !== 11'd0) begin
      failures++;
      $display("FAIL ms_rst_out got v=%b c=%0d d=%h exp all zero", out_valid, out_chan, out_data);
    end
    rst = 1'b0; mptr = 0;
    mode = 1'b0; sel = 2'd3;
    #1;
    g = model_gnt(mode, sel, in_valid, mptr);
    sbq.push_back('{chan: 2'(g), data: in_data[g*8 +: 8]});
    tick;
    e = sbq.pop_front();
    mode = 1'b1;
    repeat (2) begin
      #1;
      checks++;
      if ({out_valid, out_chan, out_data, in_ready} !== {1'b1, e.chan, e.data, 4'b0000}) begin
        failures++;
        $display("FAIL ms_held got v=%b c=%0d d=%h rdy=%b exp v=1 c=%0d d=%h rdy=0000",
                 out_valid, out_chan, out_data, in_ready, e.chan, e.data);
      end
      tick;
    end
    out_ready = 1'b1;
    #1;
    g = model_gnt(mode, sel, in_valid, mptr);
    checks++;
    if (in_ready !== rdy_of(g)) begin
      failures++;
      $display("FAIL ms_after_ready got=%b exp=%b", in_ready, rdy_of(g));
    end
    sbq.push_back('{chan: 2'(g), data: in_data[g*8 +: 8]});
    mptr = (g == 3) ? 0 : g + 1;
    tick;
    e = sbq.pop_front();
    checks++;
    if ({out_valid, out_chan, out_data} !== {1'b1, e.chan, e.data}) begin
      failures++;
      $display("FAIL ms_after_word got v=%b c=%0d d=%h exp c=%0d d=%h",
               out_valid, out_chan, out_data, e.chan, e.data);
    end
    in_valid = 4'h0;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ms_drain got=%b exp=0", out_valid);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'h0; mode = 1'b0; sel = 2'd0; out_ready = 1'b0;
    in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    in_data3 = {8'h33, 8'h22, 8'h11}; in_valid3 = 3'b000; mode3 = 1'b0;
    sel3 = 2'd0; out_ready3 = 1'b1;
    test_reset;
    test_fixed_sweep;
    test_rr_fair;
    test_backpressure;
    test_invalid_sel;
    test_reset_mode_switch;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
